// File: rtl/ara_pkg.sv
// ----------------------------------------------------------------------------
// ara_pkg
// Types and helpers shared by the lane-level blocks of the vector unit.
//   ew_e        : element width encoding (EW8 .. EW64)
//   opq_conv_e  : operand queue conversion codes, forwarded untouched
//   opq_cmd_t   : {vl, eew, conv} command pushed into an operand queue
//   calc_nwords : number of 64-bit VRF words covering vl elements of a given EEW
// ----------------------------------------------------------------------------
package ara_pkg;

    localparam int unsigned AraVlWidth = 16;

    typedef enum logic [1:0] {
        EW8  = 2'd0,
        EW16 = 2'd1,
        EW32 = 2'd2,
        EW64 = 2'd3
    } ew_e;

    typedef enum logic [2:0] {
        OpConvNone  = 3'd0,
        OpConvSext  = 3'd1,
        OpConvZext  = 3'd2,
        OpConvWiden = 3'd3,
        OpConvFp    = 3'd4,
        OpConvRsvd5 = 3'd5,
        OpConvRsvd6 = 3'd6,
        OpConvRsvd7 = 3'd7
    } opq_conv_e;

    typedef struct packed {
        logic [AraVlWidth-1:0] vl;
        ew_e                   eew;
        opq_conv_e             conv;
    } opq_cmd_t;

    // Byte count is vl << eew (up to VlWidth+3 bits); the +7 for the ceiling
    // needs one extra bit so the largest vl never wraps.
    function automatic logic [AraVlWidth:0] calc_nwords(
        input logic [AraVlWidth-1:0] vl,
        input logic [1:0]            eew
    );
        logic [AraVlWidth+3:0] bytes;
        bytes = {4'b0000, vl} << eew;
        bytes = bytes + (AraVlWidth+4)'(7);
        return bytes[AraVlWidth+3:3];
    endfunction

endpackage

// File: rtl/operand_requester_port.sv
// ----------------------------------------------------------------------------
// operand_requester_port
// Per-operand-queue read engine for one lane. Takes a read command from the
// lane sequencer, pushes its {vl, eew, conv} descriptor to the operand queue,
// then walks the source register one 64-bit word per grant, only requesting
// while the queue has credit and no hazard is flagged.
//
// Ports
//   clk_i, rst_i               clock, synchronous active-high reset
//   req_valid_i / req_ready_o  command handshake (ready only when idle)
//   req_vs_i, req_vl_i,
//   req_eew_i, req_conv_i      command fields
//   hazard_i                   suppresses new reads while high
//   vrf_req_o, vrf_addr_o,
//   vrf_bank_o, vrf_gnt_i      bank arbiter request / same-cycle grant
//   opq_ready_i                operand queue credit
//   opq_issued_o               one word issued this cycle
//   opq_cmd_o, opq_cmd_valid_o command push into the queue
//   done_o                     pulse with the last issued word
// ----------------------------------------------------------------------------
module operand_requester_port
    import ara_pkg::*;
#(
    parameter int unsigned NrBanks     = 8,
    parameter int unsigned WordsPerReg = 16,
    parameter int unsigned VlWidth     = AraVlWidth,
    localparam int unsigned AddrWidth  = $clog2(32*WordsPerReg),
    localparam int unsigned BankWidth  = $clog2(NrBanks),
    localparam int unsigned CmdWidth   = VlWidth + 2 + 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [4:0]           req_vs_i,
    input  logic [VlWidth-1:0]   req_vl_i,
    input  logic [1:0]           req_eew_i,
    input  logic [2:0]           req_conv_i,
    input  logic                 hazard_i,
    output logic                 vrf_req_o,
    output logic [AddrWidth-1:0] vrf_addr_o,
    output logic [BankWidth-1:0] vrf_bank_o,
    input  logic                 vrf_gnt_i,
    input  logic                 opq_ready_i,
    output logic                 opq_issued_o,
    output logic [CmdWidth-1:0]  opq_cmd_o,
    output logic                 opq_cmd_valid_o,
    output logic                 done_o
);

    localparam int unsigned RegShift = $clog2(WordsPerReg);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    state_e               r_state;
    state_e               w_nextState;
    logic [AddrWidth-1:0] r_base;
    logic [VlWidth:0]     r_idx;
    logic [VlWidth:0]     r_nwords;
    logic [VlWidth:0]     w_nwords;
    logic                 w_accept;
    logic                 w_issue;
    logic [AddrWidth-1:0] w_addr;
    opq_cmd_t             w_cmd;

    assign w_nwords = calc_nwords(req_vl_i, req_eew_i);
    assign w_cmd    = '{vl: req_vl_i, eew: ew_e'(req_eew_i), conv: opq_conv_e'(req_conv_i)};
    // Truncation to AddrWidth gives the v31 -> v0 wrap for free.
    assign w_addr   = r_base + r_idx[AddrWidth-1:0];

    always_comb begin
        w_nextState     = r_state;
        w_accept        = 1'b0;
        w_issue         = 1'b0;
        req_ready_o     = 1'b0;
        vrf_req_o       = 1'b0;
        vrf_addr_o      = '0;
        vrf_bank_o      = '0;
        opq_issued_o    = 1'b0;
        opq_cmd_o       = '0;
        opq_cmd_valid_o = 1'b0;
        done_o          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    // An empty command completes on the spot without bothering the queue.
                    if (w_nwords == '0) begin
                        done_o = 1'b1;
                    end else begin
                        w_accept        = 1'b1;
                        opq_cmd_valid_o = 1'b1;
                        opq_cmd_o       = w_cmd;
                        w_nextState     = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                vrf_req_o    = opq_ready_i & ~hazard_i;
                vrf_addr_o   = w_addr;
                vrf_bank_o   = w_addr[BankWidth-1:0];
                w_issue      = vrf_req_o & vrf_gnt_i;
                opq_issued_o = w_issue;
                if (w_issue && (r_idx == r_nwords - 1'b1)) begin
                    done_o      = 1'b1;
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_base   <= '0;
            r_idx    <= '0;
            r_nwords <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_accept) begin
                r_base   <= AddrWidth'({req_vs_i, {RegShift{1'b0}}});
                r_idx    <= '0;
                r_nwords <= w_nwords;
            end else if (w_issue) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_operand_requester_port.sv
// ----------------------------------------------------------------------------
// tb_operand_requester_port
// Directed bench for operand_requester_port. A word-level model (active
// command, register, words issued so far) predicts every output each cycle;
// the directed sequences add literal expectations at the interesting points.
// ----------------------------------------------------------------------------
module tb_operand_requester_port;

    logic        clk_i;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [4:0]  req_vs_i;
    logic [15:0] req_vl_i;
    logic [1:0]  req_eew_i;
    logic [2:0]  req_conv_i;
    logic        hazard_i;
    logic        vrf_req_o;
    logic [8:0]  vrf_addr_o;
    logic [2:0]  vrf_bank_o;
    logic        vrf_gnt_i;
    logic        opq_ready_i;
    logic        opq_issued_o;
    logic [20:0] opq_cmd_o;
    logic        opq_cmd_valid_o;
    logic        done_o;

    int checkCount = 0;
    int errorCount = 0;

    operand_requester_port dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_vs_i       (req_vs_i),
        .req_vl_i       (req_vl_i),
        .req_eew_i      (req_eew_i),
        .req_conv_i     (req_conv_i),
        .hazard_i       (hazard_i),
        .vrf_req_o      (vrf_req_o),
        .vrf_addr_o     (vrf_addr_o),
        .vrf_bank_o     (vrf_bank_o),
        .vrf_gnt_i      (vrf_gnt_i),
        .opq_ready_i    (opq_ready_i),
        .opq_issued_o   (opq_issued_o),
        .opq_cmd_o      (opq_cmd_o),
        .opq_cmd_valid_o(opq_cmd_valid_o),
        .done_o         (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checkCount++;
        if (actual != expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [4:0] vs, input logic [15:0] vl,
                                 input logic [1:0] eew, input logic [2:0] conv);
        req_valid_i = valid;
        req_vs_i    = vs;
        req_vl_i    = vl;
        req_eew_i   = eew;
        req_conv_i  = conv;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Word-level model: a command covers ceil(vl * 2^eew / 8) words starting
    // at vs*16, and the k-th word lives at (vs*16 + k) mod 512.
    bit modelKnown  = 1'b0;
    bit modelActive = 1'b0;
    int modelVs     = 0;
    int modelWords  = 0;
    int modelCount  = 0;

    always @(negedge clk_i) begin
        int words;
        int addr;
        bit expReady, expReq, expIssued, expCmdValid, expDone;
        longint expCmd;
        expReady = 0; expReq = 0; expIssued = 0; expCmdValid = 0; expDone = 0;
        expCmd = 0; addr = 0;
        words = (int'(req_vl_i) * (1 << req_eew_i) + 7) / 8;
        if (modelKnown) begin
            if (!modelActive) begin
                expReady = 1;
                if (req_valid_i) begin
                    if (words == 0) begin
                        expDone = 1;
                    end else begin
                        expCmdValid = 1;
                        expCmd = (longint'(req_vl_i) << 5) | (longint'(req_eew_i) << 3) | longint'(req_conv_i);
                    end
                end
            end else begin
                addr      = (modelVs * 16 + modelCount) % 512;
                expReq    = opq_ready_i && !hazard_i;
                expIssued = expReq && vrf_gnt_i;
                expDone   = expIssued && (modelCount + 1 == modelWords);
            end
            checkOutput("model req_ready", req_ready_o, expReady);
            checkOutput("model vrf_req", vrf_req_o, expReq);
            checkOutput("model vrf_addr", vrf_addr_o, addr);
            checkOutput("model vrf_bank", vrf_bank_o, addr % 8);
            checkOutput("model issued", opq_issued_o, expIssued);
            checkOutput("model cmd_valid", opq_cmd_valid_o, expCmdValid);
            checkOutput("model cmd", opq_cmd_o, expCmd);
            checkOutput("model done", done_o, expDone);
        end
        // Inputs are stable until the next rising edge, so the model can advance now.
        if (rst_i) begin
            modelKnown  = 1'b1;
            modelActive = 1'b0;
            modelCount  = 0;
        end else if (modelKnown) begin
            if (!modelActive) begin
                if (req_valid_i && words != 0) begin
                    modelActive = 1'b1;
                    modelVs     = int'(req_vs_i);
                    modelWords  = words;
                    modelCount  = 0;
                end
            end else if (expIssued) begin
                modelCount++;
                if (modelCount == modelWords) modelActive = 1'b0;
            end
        end
    end

    initial begin
        logic [20:0] cmdExp;
        rst_i       = 1'b1;
        hazard_i    = 1'b0;
        vrf_gnt_i   = 1'b1;
        opq_ready_i = 1'b1;
        applyStimulus(1'b0, 5'd0, 16'd0, 2'd0, 3'd0);
        tick();
        tick();
        @(negedge clk_i);
        checkOutput("reset req_ready", req_ready_o, 1);
        checkOutput("reset vrf_req", vrf_req_o, 0);
        tick();
        rst_i = 1'b0;

        // vs=3 vl=8 EW8: a single word at 48.
        applyStimulus(1'b1, 5'd3, 16'd8, 2'd0, 3'd0);
        cmdExp = {16'd8, 2'd0, 3'd0};
        @(negedge clk_i);
        checkOutput("t1 cmd_valid", opq_cmd_valid_o, 1);
        checkOutput("t1 cmd", opq_cmd_o, cmdExp);
        checkOutput("t1 no early req", vrf_req_o, 0);
        tick();
        applyStimulus(1'b0, 5'd0, 16'd0, 2'd0, 3'd0);
        @(negedge clk_i);
        checkOutput("t1 addr", vrf_addr_o, 48);
        checkOutput("t1 bank", vrf_bank_o, 0);
        checkOutput("t1 done", done_o, 1);
        tick();
        @(negedge clk_i);
        checkOutput("t1 ready after", req_ready_o, 1);
        tick();

        // vs=2 vl=10 EW32: five words 32..36; hazard during accept does not block it.
        hazard_i = 1'b1;
        applyStimulus(1'b1, 5'd2, 16'd10, 2'd2, 3'd1);
        @(negedge clk_i);
        checkOutput("t2 accept under hazard", opq_cmd_valid_o, 1);
        tick();
        hazard_i = 1'b0;
        applyStimulus(1'b0, 5'd0, 16'd0, 2'd0, 3'd0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk_i);
            checkOutput("t2 addr", vrf_addr_o, 31 + k);
            checkOutput("t2 bank", vrf_bank_o, k - 1);
            checkOutput("t2 done", done_o, (k == 5) ? 1 : 0);
            tick();
        end

        // Same command with the grant withheld on request cycles 2 and 3.
        applyStimulus(1'b1, 5'd2, 16'd10, 2'd2, 3'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 16'd0, 2'd0, 3'd0);
        for (int k = 1; k <= 7; k++) begin
            vrf_gnt_i = (k == 2 || k == 3) ? 1'b0 : 1'b1;
            @(negedge clk_i);
            if (k == 3) begin
                checkOutput("t3 held req", vrf_req_o, 1);
                checkOutput("t3 held addr", vrf_addr_o, 33);
                checkOutput("t3 no issue", opq_issued_o, 0);
            end
            if (k == 7) begin
                checkOutput("t3 last addr", vrf_addr_o, 36);
                checkOutput("t3 done", done_o, 1);
            end
            tick();
        end
        vrf_gnt_i = 1'b1;

        // Credit withdrawn for four cycles, then a one-cycle hazard.
        applyStimulus(1'b1, 5'd2, 16'd10, 2'd2, 3'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 16'd0, 2'd0, 3'd0);
        for (int k = 1; k <= 10; k++) begin
            opq_ready_i = (k >= 3 && k <= 6) ? 1'b0 : 1'b1;
            hazard_i    = (k == 8) ? 1'b1 : 1'b0;
            @(negedge clk_i);
            if (k == 4) begin
                checkOutput("t4 no req", vrf_req_o, 0);
                checkOutput("t4 frozen addr", vrf_addr_o, 34);
            end
            if (k == 8) checkOutput("t4 hazard no issue", opq_issued_o, 0);
            if (k == 10) checkOutput("t4 done", done_o, 1);
            tick();
        end
        opq_ready_i = 1'b1;
        hazard_i    = 1'b0;

        // vl=0 completes immediately without a push.
        applyStimulus(1'b1, 5'd4, 16'd0, 2'd1, 3'd0);
        @(negedge clk_i);
        checkOutput("t5 done", done_o, 1);
        checkOutput("t5 no push", opq_cmd_valid_o, 0);
        tick();
        applyStimulus(1'b0, 5'd0, 16'd0, 2'd0, 3'd0);
        @(negedge clk_i);
        checkOutput("t5 still idle", req_ready_o, 1);
        tick();

        // vs=31 vl=40 EW64: 40 words wrapping from 511 to 0.
        applyStimulus(1'b1, 5'd31, 16'd40, 2'd3, 3'd2);
        tick();
        applyStimulus(1'b0, 5'd0, 16'd0, 2'd0, 3'd0);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk_i);
            if (k == 16) checkOutput("t6 top addr", vrf_addr_o, 511);
            if (k == 17) checkOutput("t6 wrap addr", vrf_addr_o, 0);
            if (k == 40) begin
                checkOutput("t6 last addr", vrf_addr_o, 23);
                checkOutput("t6 done", done_o, 1);
            end
            tick();
        end

        // Reset during the third issue abandons the command.
        applyStimulus(1'b1, 5'd2, 16'd10, 2'd2, 3'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 16'd0, 2'd0, 3'd0);
        for (int k = 1; k <= 3; k++) begin
            if (k == 3) rst_i = 1'b1;
            @(negedge clk_i);
            tick();
        end
        rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("t7 ready", req_ready_o, 1);
        checkOutput("t7 req", vrf_req_o, 0);
        checkOutput("t7 issued", opq_issued_o, 0);
        checkOutput("t7 done", done_o, 0);
        checkOutput("t7 addr", vrf_addr_o, 0);
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
